// File: rtl/bcd_mult_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_mult_arbiter
//   Round-robin scheduler that shares one BCD-output multiplier core among R
//   requesters. The winner's operands are latched at grant. The core is then
//   driven through its protocol: start low for one cycle to load, then start
//   high to run until the core raises finish. The product and its BCD form are
//   returned to the winner together with a one-cycle done pulse. If the core
//   does not finish within N+SLACK run cycles, a one-cycle err pulse is issued
//   instead and the result is zeroed.
//
// Ports
//   clock       single clock, all state changes on posedge
//   reset       asynchronous, active-low reset
//   req         per-requester request level, held until done/err
//   req_a/b     packed operands, slot i = [i*N +: N]
//   gnt         one-hot grant, high from LOAD through DONE
//   done/err    one-hot single-cycle completion / timeout pulses
//   resp_out    binary product, valid while done/err is high
//   resp_bcd    BCD product from the core, valid while done/err is high
//   busy        high whenever the FSM is not IDLE
//   mul_*       connection to the shared multiplier core
// -----------------------------------------------------------------------------
module bcd_mult_arbiter #(
  parameter  int N     = 8,
  parameter  int R     = 4,
  parameter  int SLACK = 4,
  localparam int BW    = ((2 * N / 3) + 1) * 4,
  localparam int PW    = $clog2(R)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [R-1:0]      req,
  input  logic [R*N-1:0]    req_a,
  input  logic [R*N-1:0]    req_b,
  output logic [R-1:0]      gnt,
  output logic [R-1:0]      done,
  output logic [R-1:0]      err,
  output logic [2*N-1:0]    resp_out,
  output logic [BW-1:0]     resp_bcd,
  output logic              busy,
  output logic              mul_start,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic              mul_finish,
  input  logic [2*N-1:0]    mul_out,
  input  logic [BW-1:0]     mul_bcd
);

  localparam int                WDW      = $clog2(N + SLACK + 1);
  localparam logic [WDW-1:0]    WD_LIMIT = WDW'(N + SLACK - 1);
  localparam logic [R-1:0]      ONE_R    = R'(1);
  localparam logic [PW-1:0]     LAST_IDX = PW'(R - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     winner_q;
  logic [WDW-1:0]    wd_q;
  logic [R-1:0]      gnt_q;
  logic [R-1:0]      done_q;
  logic [R-1:0]      err_q;
  logic [2*N-1:0]    resp_out_q;
  logic [BW-1:0]     resp_bcd_q;
  logic              busy_q;
  logic              mul_start_q;
  logic [N-1:0]      mul_a_q;
  logic [N-1:0]      mul_b_q;

  logic [PW-1:0]     pick_s;
  logic              found_s;

  // Round-robin pick: first set request at or after ptr, wrapping modulo R.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < R; k++) begin
      int  idx;
      logic hit;
      idx     = (int'(ptr_q) + k) % R;
      hit     = !found_s && req[idx];
      pick_s  = hit ? PW'(idx) : pick_s;
      found_s = found_s | hit;
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      resp_out_q  <= '0;
      resp_bcd_q  <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          mul_start_q <= 1'b0;
          if (found_s) begin
            // Operands are captured here only; later changes on req_a/req_b
            // cannot disturb a running multiply.
            winner_q <= pick_s;
            gnt_q    <= ONE_R << pick_s;
            mul_a_q  <= req_a[pick_s*N +: N];
            mul_b_q  <= req_b[pick_s*N +: N];
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end else begin
            state_q  <= IDLE;
          end
        end
        LOAD: begin
          // start stayed low for this cycle so the core loaded the operands.
          mul_start_q <= 1'b1;
          wd_q        <= '0;
          state_q     <= RUN;
        end
        RUN: begin
          if (mul_finish) begin
            resp_out_q <= mul_out;
            resp_bcd_q <= mul_bcd;
            done_q     <= ONE_R << winner_q;
            state_q    <= DONE;
          end else if (wd_q == WD_LIMIT) begin
            resp_out_q <= '0;
            resp_bcd_q <= '0;
            err_q      <= ONE_R << winner_q;
            state_q    <= DONE;
          end else begin
            wd_q       <= wd_q + WDW'(1);
          end
        end
        DONE: begin
          mul_start_q <= 1'b0;
          gnt_q       <= '0;
          done_q      <= '0;
          err_q       <= '0;
          busy_q      <= 1'b0;
          // The requester just served becomes lowest priority.
          ptr_q       <= (winner_q == LAST_IDX) ? '0 : winner_q + PW'(1);
          state_q     <= IDLE;
        end
        default: begin
          mul_start_q <= 1'b0;
          gnt_q       <= '0;
          done_q      <= '0;
          err_q       <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign resp_out  = resp_out_q;
  assign resp_bcd  = resp_bcd_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_bcd_mult_arbiter.sv
module tb_bcd_mult_arbiter;
  localparam int N     = 8;
  localparam int R     = 4;
  localparam int SLACK = 4;
  localparam int BW    = 24;

  logic              clock;
  logic              reset;
  logic [R-1:0]      req;
  logic [R*N-1:0]    req_a;
  logic [R*N-1:0]    req_b;
  logic [R-1:0]      gnt;
  logic [R-1:0]      done;
  logic [R-1:0]      err;
  logic [2*N-1:0]    resp_out;
  logic [BW-1:0]     resp_bcd;
  logic              busy;
  logic              mul_start;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_finish;
  logic [2*N-1:0]    mul_out;
  logic [BW-1:0]     mul_bcd;

  int total = 0;
  int bad   = 0;
  bit stub  = 1'b0;

  bcd_mult_arbiter #(.N(N), .R(R), .SLACK(SLACK)) dut (
    .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .err(err), .resp_out(resp_out), .resp_bcd(resp_bcd),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_finish(mul_finish), .mul_out(mul_out), .mul_bcd(mul_bcd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural multiplier core: loads while start=0, raises finish N+1
  // edges after start goes high. stub=1 suppresses finish entirely.
  logic [N-1:0]   c_a = '0;
  logic [N-1:0]   c_b = '0;
  logic [7:0]     c_cnt = '0;
  logic           c_fin = 1'b0;
  logic [2*N-1:0] c_out = '0;
  logic [BW-1:0]  c_bcd = '0;

  function automatic logic [BW-1:0] to_bcd(input logic [2*N-1:0] v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < BW / 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (!mul_start) begin
      c_cnt <= '0;
      c_fin <= 1'b0;
      c_a   <= mul_a;
      c_b   <= mul_b;
    end else if (!c_fin) begin
      c_cnt <= c_cnt + 8'd1;
      if (c_cnt == 8'(N)) begin
        c_fin <= 1'b1;
        c_out <= c_a * c_b;
        c_bcd <= to_bcd(c_a * c_b);
      end
    end
  end

  assign mul_finish = c_fin & ~stub;
  assign mul_out    = c_out;
  assign mul_bcd    = c_bcd;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((done | err) != '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = '0;
    req_a = '0;
    req_b = '0;
    #3;
    total++;
    if ({gnt, done, err, resp_out, resp_bcd, busy, mul_start, mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b resp=%0d busy=%b start=%b want all zero",
               gnt, done, err, resp_out, busy, mul_start);
    end
    tick();
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [2*N-1:0] exp_p [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
    logic [BW-1:0]  exp_b [4] = '{24'h000010, 24'h000020, 24'h000030, 24'h000040};
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd10, 8'd10, 8'd10, 8'd10};
    req   = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rr_gnt_timeout: got no grant want grant %0d", k); end
      total++;
      if (gnt !== (4'b0001 << k)) begin bad++; $display("FAIL rr_gnt: got %b want %b", gnt, 4'b0001 << k); end
      wait_resp(ok);
      total++;
      if (done !== (4'b0001 << k)) begin bad++; $display("FAIL rr_done: got %b want %b", done, 4'b0001 << k); end
      total++;
      if (resp_out !== exp_p[k]) begin bad++; $display("FAIL rr_prod: got %0d want %0d", resp_out, exp_p[k]); end
      total++;
      if (resp_bcd !== exp_b[k]) begin bad++; $display("FAIL rr_bcd: got %h want %h", resp_bcd, exp_b[k]); end
      req[k] = 1'b0;
      tick();
      total++;
      if (done !== 4'b0000 || gnt !== 4'b0000) begin
        bad++;
        $display("FAIL rr_after_done: got done=%b gnt=%b want 0000 0000", done, gnt);
      end
    end
  endtask

  task automatic test_single_latency();
    bit early;
    req_a[7:0] = 8'd9;
    req_b[7:0] = 8'd27;
    req        = 4'b0001;
    tick();  // edge 0: grant
    total++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || mul_a !== 8'd9 || mul_b !== 8'd27 || mul_start !== 1'b0) begin
      bad++;
      $display("FAIL lat_grant: got gnt=%b busy=%b a=%0d b=%0d start=%b want 0001 1 9 27 0",
               gnt, busy, mul_a, mul_b, mul_start);
    end
    tick();  // edge 1: RUN
    total++;
    if (mul_start !== 1'b1) begin bad++; $display("FAIL lat_start: got %b want 1", mul_start); end
    early = 1'b0;
    for (int e = 2; e <= 10; e++) begin
      tick();
      if (done !== 4'b0000 || busy !== 1'b1) early = 1'b1;
    end
    total++;
    if (early) begin bad++; $display("FAIL lat_early: got done before edge 11 want none"); end
    tick();  // edge 11
    total++;
    if (done !== 4'b0001) begin bad++; $display("FAIL lat_done: got %b want 0001", done); end
    total++;
    if (resp_out !== 16'd243 || resp_bcd !== 24'h000243) begin
      bad++;
      $display("FAIL lat_result: got %0d %h want 243 000243", resp_out, resp_bcd);
    end
    req = 4'b0000;
    tick();  // edge 12
    total++;
    if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL lat_end: got done=%b gnt=%b busy=%b want 0000 0000 0", done, gnt, busy);
    end
  endtask

  task automatic test_edge_values();
    bit ok;
    logic [N-1:0]   va [2] = '{8'd255, 8'd0};
    logic [N-1:0]   vb [2] = '{8'd255, 8'd200};
    logic [2*N-1:0] ep [2] = '{16'd65025, 16'd0};
    logic [BW-1:0]  eb [2] = '{24'h065025, 24'h000000};
    for (int k = 0; k < 2; k++) begin
      req_a[7:0] = va[k];
      req_b[7:0] = vb[k];
      req        = 4'b0001;
      wait_gnt(ok);
      wait_resp(ok);
      total++;
      if (!ok || done !== 4'b0001 || err !== 4'b0000) begin
        bad++;
        $display("FAIL edge_done: got done=%b err=%b want 0001 0000", done, err);
      end
      total++;
      if (resp_out !== ep[k] || resp_bcd !== eb[k]) begin
        bad++;
        $display("FAIL edge_result: got %0d %h want %0d %h", resp_out, resp_bcd, ep[k], eb[k]);
      end
      req = 4'b0000;
      tick();
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    req_a[15:8] = 8'd12;
    req_b[15:8] = 8'd5;
    req         = 4'b0010;
    wait_gnt(ok);
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL b2b_gnt1: got %b want 0010", gnt); end
    tick();
    tick();
    // Mid-RUN: requester 1 withdraws, requester 2 arrives, operands of 1 change.
    req          = 4'b0100;
    req_a[15:8]  = 8'd99;
    req_a[23:16] = 8'd7;
    req_b[23:16] = 8'd3;
    wait_resp(ok);
    total++;
    if (done !== 4'b0010) begin bad++; $display("FAIL b2b_done1: got %b want 0010", done); end
    total++;
    if (resp_out !== 16'd60 || resp_bcd !== 24'h000060) begin
      bad++;
      $display("FAIL b2b_res1: got %0d %h want 60 000060", resp_out, resp_bcd);
    end
    tick();
    total++;
    if (gnt !== 4'b0000 || done !== 4'b0000) begin
      bad++;
      $display("FAIL b2b_gap: got gnt=%b done=%b want 0000 0000", gnt, done);
    end
    tick();
    total++;
    if (gnt !== 4'b0100) begin bad++; $display("FAIL b2b_gnt2: got %b want 0100", gnt); end
    wait_resp(ok);
    total++;
    if (done !== 4'b0100 || resp_out !== 16'd21 || resp_bcd !== 24'h000021) begin
      bad++;
      $display("FAIL b2b_res2: got done=%b %0d %h want 0100 21 000021", done, resp_out, resp_bcd);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    bit ok;
    bit early;
    stub       = 1'b1;
    req_a[7:0] = 8'd3;
    req_b[7:0] = 8'd3;
    req        = 4'b0001;
    wait_gnt(ok);
    tick();  // RUN entered
    early = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (err !== 4'b0000 || done !== 4'b0000) early = 1'b1;
    end
    total++;
    if (early) begin bad++; $display("FAIL wd_early: got response before 12 RUN cycles want none"); end
    tick();
    total++;
    if (err !== 4'b0001 || done !== 4'b0000) begin
      bad++;
      $display("FAIL wd_err: got err=%b done=%b want 0001 0000", err, done);
    end
    total++;
    if (resp_out !== 16'd0 || resp_bcd !== 24'h000000) begin
      bad++;
      $display("FAIL wd_resp: got %0d %h want 0 000000", resp_out, resp_bcd);
    end
    req = 4'b0000;
    tick();
    total++;
    if (err !== 4'b0000 || mul_start !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL wd_after: got err=%b start=%b gnt=%b want 0000 0 0000", err, mul_start, gnt);
    end
    stub = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    req_a[23:16] = 8'd1;
    req_b[23:16] = 8'd1;
    req          = 4'b0100;
    wait_gnt(ok);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({gnt, done, err, resp_out, resp_bcd, busy, mul_start, mul_a, mul_b} !== '0) begin
      bad++;
      $display("FAIL rst_mid: got gnt=%b busy=%b start=%b a=%0d want all zero", gnt, busy, mul_start, mul_a);
    end
    req          = 4'b1001;
    req_a[7:0]   = 8'd4;
    req_b[7:0]   = 8'd6;
    req_a[31:24] = 8'd9;
    req_b[31:24] = 8'd9;
    @(negedge clock);
    reset = 1'b1;
    wait_gnt(ok);
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_ptr: got %b want 0001", gnt); end
    wait_resp(ok);
    total++;
    if (done !== 4'b0001 || resp_out !== 16'd24 || resp_bcd !== 24'h000024) begin
      bad++;
      $display("FAIL rst_serve: got done=%b %0d %h want 0001 24 000024", done, resp_out, resp_bcd);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_latency();
    test_edge_values();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
